// File: rtl/inert_seq_if.sv
// rtl/inert_seq_if.sv - SPI master command/response bundle driven by the inertial sequencer
interface inert_seq_if;
    logic        wrt;
    logic [15:0] cmd;
    logic        done;
    logic [15:0] rd_data;

    modport master (output wrt, output cmd, input done, input rd_data);
    modport slave  (input wrt, input cmd, output done, output rd_data);
endinterface

// File: rtl/inert_seq.sv
// rtl/inert_seq.sv - inertial sensor sequencer: power-up wait, config writes, yaw-rate reads
module inert_seq #(
    parameter int          WAIT_BITS = 16,
    parameter logic [15:0] CFG0      = 16'h0D02,
    parameter logic [15:0] CFG1      = 16'h1160,
    parameter logic [15:0] CFG2      = 16'h1440,
    parameter logic [15:0] RD_YAWL   = 16'hA600,
    parameter logic [15:0] RD_YAWH   = 16'hA700
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               INT,
    inert_seq_if.master        spi,
    output logic [15:0]        yaw_rt,
    output logic               vld,
    output logic               init_done
);

    typedef enum logic [2:0] {
        PWR_WAIT,
        W_CFG0,
        W_CFG1,
        W_CFG2,
        IDLE,
        W_YAWL,
        W_YAWH
    } state_t;

    state_t               state, state_nxt;
    logic [WAIT_BITS-1:0] timer;
    logic                 timer_full;
    logic                 int_s1, int_s2;
    logic                 done_q, done_rise;
    logic [7:0]           low_hold, low_hold_nxt;
    logic                 wrt_nxt, vld_nxt, init_nxt;
    logic [15:0]          cmd_nxt, yaw_nxt;

    // Upper byte of each read word carries the echoed command, not data.
    logic unused_rd_hi;
    assign unused_rd_hi = ^spi.rd_data[15:8];

    assign timer_full = &timer;
    assign done_rise  = spi.done & ~done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= PWR_WAIT;
            timer     <= '0;
            int_s1    <= 1'b0;
            int_s2    <= 1'b0;
            done_q    <= 1'b0;
            low_hold  <= 8'h00;
            spi.wrt   <= 1'b0;
            spi.cmd   <= 16'h0000;
            yaw_rt    <= 16'h0000;
            vld       <= 1'b0;
            init_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            int_s1    <= INT;
            int_s2    <= int_s1;
            done_q    <= spi.done;
            low_hold  <= low_hold_nxt;
            spi.wrt   <= wrt_nxt;
            spi.cmd   <= cmd_nxt;
            yaw_rt    <= yaw_nxt;
            vld       <= vld_nxt;
            init_done <= init_nxt;
            // Saturates so a long power-up wait cannot wrap and restart.
            if (state == PWR_WAIT && !timer_full) begin
                timer <= timer + {{(WAIT_BITS-1){1'b0}}, 1'b1};
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        wrt_nxt      = 1'b0;
        cmd_nxt      = spi.cmd;
        yaw_nxt      = yaw_rt;
        vld_nxt      = 1'b0;
        init_nxt     = init_done;
        low_hold_nxt = low_hold;
        case (state)
            PWR_WAIT: begin
                if (timer_full) begin
                    wrt_nxt   = 1'b1;
                    cmd_nxt   = CFG0;
                    state_nxt = W_CFG0;
                end
            end
            W_CFG0: begin
                if (done_rise) begin
                    wrt_nxt   = 1'b1;
                    cmd_nxt   = CFG1;
                    state_nxt = W_CFG1;
                end
            end
            W_CFG1: begin
                if (done_rise) begin
                    wrt_nxt   = 1'b1;
                    cmd_nxt   = CFG2;
                    state_nxt = W_CFG2;
                end
            end
            W_CFG2: begin
                if (done_rise) begin
                    init_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            IDLE: begin
                if (int_s2) begin
                    wrt_nxt   = 1'b1;
                    cmd_nxt   = RD_YAWL;
                    state_nxt = W_YAWL;
                end
            end
            W_YAWL: begin
                if (done_rise) begin
                    low_hold_nxt = spi.rd_data[7:0];
                    wrt_nxt      = 1'b1;
                    cmd_nxt      = RD_YAWH;
                    state_nxt    = W_YAWH;
                end
            end
            W_YAWH: begin
                if (done_rise) begin
                    yaw_nxt   = {spi.rd_data[7:0], low_hold};
                    vld_nxt   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = PWR_WAIT;
            end
        endcase
    end

endmodule

// File: tb/tb_inert_seq.sv
// tb/tb_inert_seq.sv - randomized scoreboard bench for the inertial sequencer
module tb_inert_seq;
    localparam logic [15:0] CFG0    = 16'h0D02;
    localparam logic [15:0] CFG1    = 16'h1160;
    localparam logic [15:0] CFG2    = 16'h1440;
    localparam logic [15:0] RD_YAWL = 16'hA600;
    localparam logic [15:0] RD_YAWH = 16'hA700;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        int_in = 1'b0;
    logic [15:0] yaw_rt;
    logic        vld;
    logic        init_done;

    inert_seq_if spi();

    inert_seq #(.WAIT_BITS(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .INT       (int_in),
        .spi       (spi),
        .yaw_rt    (yaw_rt),
        .vld       (vld),
        .init_done (init_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rel_cyc = 0;
    int cfg2_done_cyc = -100;
    int vld_count = 0;
    int wrt_count = 0;

    logic [15:0] yaw_q[$];
    int          vld_cyc_q[$];

    int       lat_min = 3;
    int       lat_max = 40;
    bit       force_data = 1'b0;
    logic [7:0] f_lo = 8'h00;
    logic [7:0] f_hi = 8'h00;
    bit       int_hold = 1'b0;
    int       int_req = 0;
    int       int_served = 0;
    int       wig_req = 0;
    int       wig_ack = 0;
    bit       in_yawh = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] exp_cmd(input int i);
        if (i == 0) return CFG0;
        if (i == 1) return CFG1;
        if (i == 2) return CFG2;
        return ((i - 3) % 2 == 0) ? RD_YAWL : RD_YAWH;
    endfunction

    initial begin : cycle_counter
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Sensor + SPI master model: owns INT, done and rd_data.
    initial begin : spi_model
        int          cnt;
        logic [15:0] pcmd;
        logic [7:0]  lo_byte;
        logic [7:0]  hi_byte;
        cnt = 0;
        pcmd = 16'h0000;
        lo_byte = 8'h00;
        spi.done = 1'b0;
        spi.rd_data = 16'h0000;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                cnt = 0;
                spi.done = 1'b0;
                in_yawh = 1'b0;
            end else if (spi.wrt) begin
                spi.done = 1'b0;
                pcmd = spi.cmd;
                cnt = $urandom_range(lat_max, lat_min);
                if (spi.cmd == RD_YAWH) begin
                    in_yawh = 1'b1;
                    if (int_served != int_req) int_served++;
                end
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    if (pcmd == RD_YAWL) begin
                        lo_byte = force_data ? f_lo : 8'($urandom);
                        spi.rd_data = {8'($urandom), lo_byte};
                    end else if (pcmd == RD_YAWH) begin
                        hi_byte = force_data ? f_hi : 8'($urandom);
                        spi.rd_data = {8'($urandom), hi_byte};
                        yaw_q.push_back({hi_byte, lo_byte});
                        vld_cyc_q.push_back(cyc + 1);
                        in_yawh = 1'b0;
                    end else begin
                        spi.rd_data = 16'($urandom);
                        if (pcmd == CFG2) cfg2_done_cyc = cyc;
                    end
                    spi.done = 1'b1;
                end
            end else if (wig_ack != wig_req) begin
                spi.done = ~spi.done;
                wig_ack++;
            end
            int_in = int_hold || (int_req != int_served);
        end
    end

    initial begin : monitor
        bit          prev_wrt;
        bit          prev_vld;
        bit          prev_init;
        int          idx;
        int          d;
        int          last_vld_cyc;
        logic [15:0] last_cmd;
        logic [15:0] last_yaw;
        logic [15:0] ec;
        prev_wrt = 0; prev_vld = 0; prev_init = 0; idx = 0;
        last_vld_cyc = -100; last_cmd = 16'h0000; last_yaw = 16'h0000;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_wrt = 0; prev_vld = 0; prev_init = 0; idx = 0;
                last_cmd = 16'h0000; last_yaw = 16'h0000;
                continue;
            end
            if (spi.wrt) begin
                wrt_count++;
                check("wrt_single_cycle", {31'd0, prev_wrt}, 32'd0);
                ec = exp_cmd(idx);
                check("cmd_sequence", {16'd0, spi.cmd}, {16'd0, ec});
                if (idx == 0) begin
                    d = cyc - rel_cyc;
                    checks++;
                    if (!(d == 15 || d == 16)) begin
                        errors++;
                        $display("FAIL first_wrt_delay: got %0d cycles after release, expected 15..16", d);
                    end
                end
                if (ec == RD_YAWL) begin
                    check("read_after_init", {31'd0, init_done}, 32'd1);
                    if (int_hold && idx > 3)
                        check("back_to_back_read", cyc, last_vld_cyc + 1);
                end
                idx++;
                last_cmd = spi.cmd;
            end else begin
                check("cmd_hold", {16'd0, spi.cmd}, {16'd0, last_cmd});
            end
            if (vld) begin
                vld_count++;
                check("vld_single_cycle", {31'd0, prev_vld}, 32'd0);
                if (yaw_q.size() == 0) begin
                    check("vld_unexpected", 32'd1, 32'd0);
                end else begin
                    check("yaw_rt_value", {16'd0, yaw_rt}, {16'd0, yaw_q.pop_front()});
                    check("vld_latency", cyc, vld_cyc_q.pop_front());
                end
                last_yaw = yaw_rt;
                last_vld_cyc = cyc;
            end else begin
                check("yaw_rt_hold", {16'd0, yaw_rt}, {16'd0, last_yaw});
            end
            if (init_done && !prev_init) check("init_done_latency", cyc, cfg2_done_cyc + 1);
            if (!init_done && prev_init) check("init_done_sticky", {31'd0, init_done}, 32'd1);
            prev_wrt = spi.wrt;
            prev_vld = vld;
            prev_init = init_done;
        end
    end

    task automatic check_reset_values();
        check("rst_wrt", {31'd0, spi.wrt}, 32'd0);
        check("rst_cmd", {16'd0, spi.cmd}, 32'd0);
        check("rst_yaw_rt", {16'd0, yaw_rt}, 32'd0);
        check("rst_vld", {31'd0, vld}, 32'd0);
        check("rst_init_done", {31'd0, init_done}, 32'd0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        rel_cyc = cyc;
    endtask

    task automatic wait_init(input int budget);
        int n = 0;
        while (!init_done && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("init_done_reached", {31'd0, init_done}, 32'd1);
    endtask

    task automatic wait_vld(input int target, input int budget);
        int n = 0;
        while (vld_count < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("vld_reached", {31'd0, vld_count >= target}, 32'd1);
        @(negedge clk);
    endtask

    initial begin : main
        int w0;
        int v0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values();
        release_reset();
        wait_init(400);

        force_data = 1'b1;
        f_lo = 8'h34; f_hi = 8'h12;
        int_req++;
        wait_vld(vld_count + 1, 400);
        check("yaw_1234", {16'd0, yaw_rt}, 32'h0000_1234);

        f_lo = 8'hF0; f_hi = 8'hFF;
        int_req++;
        wait_vld(vld_count + 1, 400);
        repeat (20) @(negedge clk);
        check("yaw_fff0_held", {16'd0, yaw_rt}, 32'h0000_FFF0);

        force_data = 1'b0;
        for (int i = 0; i < 15; i++) begin
            repeat ($urandom_range(10, 0)) @(negedge clk);
            int_req++;
            wait_vld(vld_count + 1, 400);
        end

        // Stale and re-rising done while idle must not advance anything.
        repeat (5) @(negedge clk);
        w0 = wrt_count;
        v0 = vld_count;
        wig_req += 6;
        repeat (30) @(negedge clk);
        check("idle_done_no_wrt", wrt_count, w0);
        check("idle_done_no_vld", vld_count, v0);

        // INT held high from reset: reads only after init, then back-to-back.
        @(negedge clk);
        rst_n = 1'b0;
        int_hold = 1'b1;
        repeat (3) @(negedge clk);
        release_reset();
        wait_init(400);
        wait_vld(vld_count + 4, 800);
        int_hold = 1'b0;
        repeat (200) @(negedge clk);

        // Reset while waiting for the high-byte read.
        lat_min = 30; lat_max = 30;
        int_req++;
        begin
            int n = 0;
            while (!in_yawh && n < 400) begin
                @(negedge clk);
                n++;
            end
            check("reached_w_yawh", {31'd0, in_yawh}, 32'd1);
        end
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_values();
        lat_min = 3; lat_max = 40;
        repeat (3) @(negedge clk);
        release_reset();
        wait_init(400);
        int_req++;
        wait_vld(vld_count + 1, 400);
        repeat (10) @(negedge clk);

        check("scoreboard_drained", yaw_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
